// File: rtl/interrupt_controller_pkg.sv
// Shared definitions for the interrupt controller: register map offsets,
// FSM state type and the system memory-map base of the register window.
package interrupt_controller_pkg;

    localparam logic [7:0] IC_BASE_ADDR = 8'hE0;

    localparam logic [1:0] OFF_PENDING = 2'd0;
    localparam logic [1:0] OFF_MASK    = 2'd1;
    localparam logic [1:0] OFF_STATUS  = 2'd2;
    localparam logic [1:0] OFF_SOFT    = 2'd3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESENT = 2'd1,
        ACKING  = 2'd2
    } ic_state_e;

    function automatic logic [7:0] onehot8(input logic [2:0] idx);
        return 8'h01 << idx;
    endfunction

endpackage

// File: rtl/interrupt_controller_if.sv
// Bus address/strobe and CPU interrupt handshake of the interrupt controller.
// The data bus is tristated and stays a plain inout port on the top.
interface interrupt_controller_if;
    logic [7:0] BUS_ADDR;
    logic       BUS_WE;
    logic       CPU_INT_RAISE;
    logic [2:0] CPU_INT_ID;
    logic       CPU_INT_ACK;

    modport slave  (input  BUS_ADDR, BUS_WE, CPU_INT_ACK,
                    output CPU_INT_RAISE, CPU_INT_ID);
    modport master (output BUS_ADDR, BUS_WE, CPU_INT_ACK,
                    input  CPU_INT_RAISE, CPU_INT_ID);
endinterface

// File: rtl/interrupt_controller_int_priority_enc.sv
// Combinational lowest-index-first priority encoder over 8 requests.
module int_priority_enc (
    input  logic [7:0] req,
    output logic       valid,
    output logic [2:0] id
);
    always_comb begin
        valid = |req;
        id    = '0;
        for (int i = 7; i >= 0; i--) begin
            if (req[i]) id = 3'(i);
        end
    end
endmodule

// File: rtl/interrupt_controller.sv
// Edge-latching interrupt controller: pending/mask registers on a small bus
// window, one interrupt presented to the CPU at a time, ACK routed back.
module interrupt_controller
    import interrupt_controller_pkg::*;
#(
    parameter logic [7:0] BASE_ADDR = IC_BASE_ADDR,
    parameter int         NUM_SRC   = 4,
    parameter logic [7:0] INIT_MASK = 8'h0F
) (
    input  logic                 CLK,
    input  logic                 RST,
    interrupt_controller_if.slave bus,
    inout  wire  [7:0]           BUS_DATA,
    input  logic [NUM_SRC-1:0]   SRC_RAISE,
    output logic [NUM_SRC-1:0]   SRC_ACK
);
    // Bits at or above NUM_SRC are tied off in every register.
    localparam logic [7:0] SRC_BITS = 8'((9'h1 << NUM_SRC) - 9'h1);

    ic_state_e  state, state_nxt;
    logic [2:0] id_q, id_nxt;
    logic [7:0] pend, pend_nxt, mask, raise_q, raise_ext;
    logic [7:0] req, edge_set, w1c_clr, ack_clr, soft_set;
    logic [NUM_SRC-1:0] ack_nxt;
    logic       enc_vld;
    logic [2:0] enc_id;
    logic [7:0] off;
    logic       in_win, wr;
    logic       cpu_raise_q;
    logic       rd_en_q;
    logic [7:0] rd_data, rd_data_q;

    assign off    = bus.BUS_ADDR - BASE_ADDR;
    assign in_win = (off[7:2] == 6'd0);
    assign wr     = in_win & bus.BUS_WE;
    assign req    = pend & mask;

    int_priority_enc u_enc (
        .req   (req),
        .valid (enc_vld),
        .id    (enc_id)
    );

    always_comb begin
        raise_ext = '0;
        raise_ext[NUM_SRC-1:0] = SRC_RAISE;
        edge_set = raise_ext & ~raise_q;
        w1c_clr  = (wr && off[1:0] == OFF_PENDING) ? BUS_DATA : 8'h00;
        soft_set = (wr && off[1:0] == OFF_SOFT)    ? BUS_DATA : 8'h00;
        ack_clr  = 8'h00;
        // The presented source is committed: software cannot clear it under the CPU.
        if (state == PRESENT) begin
            w1c_clr = w1c_clr & ~onehot8(id_q);
            if (bus.CPU_INT_ACK) ack_clr = onehot8(id_q);
        end
        pend_nxt = ((pend & ~w1c_clr & ~ack_clr) | edge_set | soft_set) & SRC_BITS;
    end

    always_comb begin
        state_nxt = state;
        id_nxt    = id_q;
        ack_nxt   = '0;
        case (state)
            IDLE: begin
                if (enc_vld) begin
                    state_nxt = PRESENT;
                    id_nxt    = enc_id;
                end
            end
            PRESENT: begin
                if (bus.CPU_INT_ACK) begin
                    state_nxt = ACKING;
                    ack_nxt   = NUM_SRC'(onehot8(id_q));
                end
            end
            ACKING:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        rd_data = '0;
        case (off[1:0])
            OFF_PENDING: rd_data = pend;
            OFF_MASK:    rd_data = mask;
            OFF_STATUS:  rd_data = {cpu_raise_q, 4'b0, id_q};
            default:     rd_data = '0;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state       <= IDLE;
            id_q        <= '0;
            pend        <= '0;
            mask        <= INIT_MASK & SRC_BITS;
            raise_q     <= '0;
            SRC_ACK     <= '0;
            cpu_raise_q <= 1'b0;
            rd_en_q     <= 1'b0;
            rd_data_q   <= '0;
        end else begin
            state       <= state_nxt;
            id_q        <= id_nxt;
            pend        <= pend_nxt;
            raise_q     <= raise_ext;
            SRC_ACK     <= ack_nxt;
            cpu_raise_q <= (state_nxt == PRESENT);
            rd_en_q     <= in_win & ~bus.BUS_WE;
            rd_data_q   <= rd_data;
            if (wr && off[1:0] == OFF_MASK) mask <= BUS_DATA & SRC_BITS;
        end
    end

    assign bus.CPU_INT_RAISE = cpu_raise_q;
    assign bus.CPU_INT_ID    = id_q;
    assign BUS_DATA          = rd_en_q ? rd_data_q : 8'hzz;

endmodule

// File: tb/tb_interrupt_controller.sv
// Directed plus randomized bench for interrupt_controller against a
// cycle-level reference model of the pending/mask/presentation rules.
module tb_interrupt_controller;
    localparam int         NS     = 4;
    localparam logic [7:0] BASE   = 8'hE0;
    localparam logic [7:0] VMASK  = 8'h0F;
    localparam logic [7:0] NOADDR = 8'h00;

    logic CLK = 1'b0;
    logic RST;
    always #5 CLK = ~CLK;

    interrupt_controller_if bif ();
    wire  [7:0]    bus_data;
    logic          drv_en;
    logic [7:0]    drv_data;
    logic [NS-1:0] src_raise, src_ack;

    assign bus_data = drv_en ? drv_data : 8'hzz;
    // An undriven bus resolves to 8'hFF.
    for (genvar b = 0; b < 8; b++) begin : g_pu
        pullup pu (bus_data[b]);
    end

    interrupt_controller #(
        .BASE_ADDR (BASE),
        .NUM_SRC   (NS),
        .INIT_MASK (8'h0F)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .bus       (bif),
        .BUS_DATA  (bus_data),
        .SRC_RAISE (src_raise),
        .SRC_ACK   (src_ack)
    );

    int errs = 0, checks = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model state, as seen just after each clock edge.
    logic [7:0]    m_pend, m_mask, m_rq, m_rd;
    logic [2:0]    m_id;
    logic [NS-1:0] m_ack;
    bit            m_pres, m_gap, m_rd_en;
    logic [NS-1:0] rs;

    task automatic model_step(input bit we, input logic [7:0] addr, input logic [7:0] data,
                              input bit ack, input bit rst);
        logic [7:0] off, clr, set, req, raise8;
        bit inwin;
        if (rst) begin
            m_pend = 0; m_mask = VMASK; m_rq = 0; m_id = 0; m_ack = 0;
            m_pres = 0; m_gap = 0; m_rd_en = 0; m_rd = 0;
            return;
        end
        raise8  = {4'b0, rs};
        off     = addr - BASE;
        inwin   = (off < 8'd4);
        m_rd_en = inwin && !we;
        case (off)
            8'd0:    m_rd = m_pend;
            8'd1:    m_rd = m_mask;
            8'd2:    m_rd = {m_pres, 4'b0, m_id};
            default: m_rd = 8'h00;
        endcase
        set = raise8 & ~m_rq;
        clr = 8'h00;
        if (we && inwin && off == 8'd0) clr = data & ~(m_pres ? (8'h01 << m_id) : 8'h00);
        if (we && inwin && off == 8'd3) set = set | data;
        m_ack = '0;
        if (m_pres) begin
            if (ack) begin
                clr    = clr | (8'h01 << m_id);
                m_ack  = NS'(8'h01 << m_id);
                m_pres = 0;
                m_gap  = 1;
            end
        end else if (m_gap) begin
            m_gap = 0;
        end else begin
            req = m_pend & m_mask;
            if (req != 0) begin
                for (int i = 7; i >= 0; i--) if (req[i]) m_id = 3'(i);
                m_pres = 1;
            end
        end
        if (we && inwin && off == 8'd1) m_mask = data & VMASK;
        m_pend = ((m_pend & ~clr) | set) & VMASK;
        m_rq   = raise8;
    endtask

    // One clock: drive at the falling edge, model the rising edge, check after it.
    task automatic cyc(input bit we, input logic [7:0] addr, input logic [7:0] data,
                       input bit ack, input bit rst);
        src_raise       = rs;
        RST             = rst;
        bif.CPU_INT_ACK = ack;
        bif.BUS_WE      = we;
        bif.BUS_ADDR    = addr;
        drv_en          = we;
        drv_data        = data;
        model_step(we, addr, data, ack, rst);
        @(posedge CLK);
        #1 drv_en = 1'b0;
        @(negedge CLK);
        chk("cpu_raise", bif.CPU_INT_RAISE, m_pres);
        chk("cpu_id", bif.CPU_INT_ID, m_id);
        chk("src_ack", src_ack, m_ack);
        chk("bus_data", bus_data, m_rd_en ? m_rd : 8'hFF);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, NOADDR, 8'h00, 0, 0);
    endtask

    initial begin
        bit we, ack, rst, prev_rd;
        logic [7:0] addr, data;
        logic [NS-1:0] acked;
        int r;
        rs = '0; src_raise = '0; RST = 1'b1; drv_en = 1'b0; drv_data = '0;
        bif.BUS_ADDR = NOADDR; bif.BUS_WE = 1'b0; bif.CPU_INT_ACK = 1'b0;
        @(negedge CLK);

        // Reset state and register readback.
        cyc(0, NOADDR, 0, 0, 1);
        cyc(0, NOADDR, 0, 0, 1);
        chk("rst_raise", bif.CPU_INT_RAISE, 1'b0);
        chk("rst_bus_z", bus_data, 8'hFF);
        cyc(0, BASE + 8'd1, 0, 0, 0);
        chk("rst_mask", bus_data, 8'h0F);
        cyc(0, BASE, 0, 0, 0);
        chk("rst_pend", bus_data, 8'h00);
        idle(1);
        chk("idle_z", bus_data, 8'hFF);

        // Single source: two-edge latency, ack pulse, held level does not re-pend.
        rs = 4'b0001;
        idle(1);
        chk("s0_not_yet", bif.CPU_INT_RAISE, 1'b0);
        idle(1);
        chk("s0_raise", bif.CPU_INT_RAISE, 1'b1);
        chk("s0_id", bif.CPU_INT_ID, 3'd0);
        cyc(0, NOADDR, 0, 1, 0);
        chk("s0_ack", src_ack, 4'b0001);
        cyc(0, BASE, 0, 0, 0);
        chk("s0_pend_clr", bus_data, 8'h00);
        chk("s0_ack_once", src_ack, 4'b0000);
        idle(3);
        chk("s0_no_rerais", bif.CPU_INT_RAISE, 1'b0);

        // Simultaneous edges are served lowest index first with a gap.
        rs = 4'b0110;
        idle(2);
        chk("m_id1", bif.CPU_INT_ID, 3'd1);
        cyc(0, NOADDR, 0, 1, 0);
        chk("m_ack1", src_ack, 4'b0010);
        idle(1);
        chk("m_gap", bif.CPU_INT_RAISE, 1'b0);
        idle(1);
        chk("m_raise2", bif.CPU_INT_RAISE, 1'b1);
        chk("m_id2", bif.CPU_INT_ID, 3'd2);
        cyc(0, NOADDR, 0, 1, 0);
        chk("m_ack2", src_ack, 4'b0100);
        rs = 4'b0000;
        idle(2);

        // Masked source pends silently; unmasking presents; W1C cannot withdraw it.
        cyc(1, BASE + 8'd1, 8'h0E, 0, 0);
        rs = 4'b0001;
        idle(3);
        chk("mask_quiet", bif.CPU_INT_RAISE, 1'b0);
        cyc(0, BASE, 0, 0, 0);
        chk("mask_pend", bus_data, 8'h01);
        idle(1);
        cyc(1, BASE + 8'd1, 8'h0F, 0, 0);
        idle(1);
        chk("unmask_raise", bif.CPU_INT_RAISE, 1'b1);
        chk("unmask_id", bif.CPU_INT_ID, 3'd0);
        cyc(1, BASE, 8'h01, 0, 0);
        idle(1);
        chk("w1c_held", bif.CPU_INT_RAISE, 1'b1);
        cyc(0, BASE, 0, 0, 0);
        chk("w1c_ignored", bus_data, 8'h01);
        idle(1);
        cyc(0, NOADDR, 0, 1, 0);
        rs = 4'b0000;
        idle(2);

        // Edge and W1C on the same bit in one cycle: the set wins.
        cyc(1, BASE + 8'd1, 8'h00, 0, 0);
        rs = 4'b1000;
        cyc(1, BASE, 8'h08, 0, 0);
        idle(1);
        cyc(0, BASE, 0, 0, 0);
        chk("set_wins", bus_data, 8'h08);
        idle(1);
        cyc(1, BASE, 8'h08, 0, 0);
        cyc(0, BASE, 0, 0, 0);
        chk("w1c_clears", bus_data, 8'h00);
        idle(1);
        cyc(1, BASE + 8'd1, 8'h0F, 0, 0);

        // Soft set presents a source, STATUS shows it; upper bits ignored.
        cyc(1, BASE + 8'd3, 8'hF8, 0, 0);
        idle(1);
        chk("soft_id", bif.CPU_INT_ID, 3'd3);
        cyc(0, BASE + 8'd2, 0, 0, 0);
        chk("status", bus_data, 8'h83);
        cyc(0, BASE + 8'd3, 0, 0, 0);
        chk("soft_rd0", bus_data, 8'h00);
        cyc(0, NOADDR, 0, 1, 0);
        rs = 4'b0000;
        idle(2);

        // Reset mid-presentation: no ack pulse, held source re-presents.
        rs = 4'b0100;
        idle(2);
        chk("rp_id", bif.CPU_INT_ID, 3'd2);
        cyc(0, NOADDR, 0, 1, 1);
        chk("rp_no_ack", src_ack, 4'b0000);
        chk("rp_drop", bif.CPU_INT_RAISE, 1'b0);
        cyc(0, NOADDR, 0, 0, 1);
        idle(2);
        chk("rp_re_raise", bif.CPU_INT_RAISE, 1'b1);
        chk("rp_re_id", bif.CPU_INT_ID, 3'd2);
        cyc(0, NOADDR, 0, 1, 0);
        rs = 4'b0000;
        idle(2);

        // Randomized traffic against the model.
        acked = '0; prev_rd = 0;
        for (int n = 0; n < 600; n++) begin
            for (int i = 0; i < NS; i++) begin
                if (m_ack[i]) acked[i] = 1'b1;
                if (!rs[i]) begin
                    if ($urandom_range(7) == 0) rs[i] = 1'b1;
                end else if (acked[i] ? ($urandom_range(1) == 0) : ($urandom_range(39) == 0)) begin
                    rs[i] = 1'b0;
                    acked[i] = 1'b0;
                end
            end
            we = 0; addr = NOADDR; data = 8'($urandom);
            r = $urandom_range(9);
            if (r >= 4 && r <= 5) addr = BASE + 8'($urandom_range(3));
            else if (r == 6) addr = $urandom_range(1) ? BASE + 8'd4 : BASE - 8'd1;
            else if (r >= 7 && !prev_rd) begin
                we = 1;
                addr = BASE + ((r == 7) ? 8'd0 : (r == 8) ? 8'd1 : 8'd3);
                if (r == 9) data = 8'h01 << $urandom_range(7);
            end
            ack = m_pres ? ($urandom_range(2) == 0) : ($urandom_range(3) == 0);
            rst = ($urandom_range(249) == 0);
            cyc(we, addr, data, ack, rst);
            prev_rd = m_rd_en;
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
